// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit/flush trace unit: retire bundle, entry kind and trace entry layout.
package commit_trace_buffer_pkg;

  localparam int unsigned TraceTsW = 32;

  // Retire-side register write bundle; layout matches the core's writeback-to-ARF struct.
  typedef struct packed {
    logic        valid_commit;
    logic        flushed;
    logic        valid_write;
    logic [5:0]  pdst;
    logic [31:0] data;
  } writeback_toARF;

  typedef enum logic {
    COMMIT = 1'b0,
    FLUSH  = 1'b1
  } trace_kind_e;

  typedef struct packed {
    trace_kind_e         kind;
    logic [TraceTsW-1:0] ts;
    logic [31:0]         payload;
    logic [5:0]          tag;
  } trace_entry_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Valid/ready drain port carrying trace entries out of the buffer.
interface commit_trace_buffer_if
  import commit_trace_buffer_pkg::*;
();
  logic         valid;
  logic         ready;
  trace_entry_t entry;

  modport master (output valid, output entry, input ready);
  modport slave  (input valid, input entry, output ready);
endinterface

// File: rtl/trace_fifo_2w1r.sv
// Circular buffer with two write ports (slot order a then b) and one first-word-fall-through read.
module trace_fifo_2w1r
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_a_en,
  input  trace_entry_t               wr_a_data,
  input  logic                       wr_b_en,
  input  trace_entry_t               wr_b_data,
  input  logic                       rd_en,
  output trace_entry_t               rd_data,
  output logic                       empty,
  output logic [$clog2(Depth):0]     free_cnt
);
  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] occupancy, n_wr;
  logic [AW-1:0] widx0, widx1;
  logic          full, we0, we1;
  trace_entry_t  wdata0;
  trace_entry_t  mem_q [Depth];

  always_comb begin
    occupancy = wptr_q - rptr_q;
    empty     = (wptr_q == rptr_q);
    full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    free_cnt  = full ? '0 : PW'(Depth) - occupancy;
    rd_data   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    // A lone b-write compacts into the first free slot.
    we0       = wr_a_en | wr_b_en;
    we1       = wr_a_en & wr_b_en;
    wdata0    = wr_a_en ? wr_a_data : wr_b_data;
    widx0     = wptr_q[AW-1:0];
    widx1     = wptr_q[AW-1:0] + AW'(1);
    n_wr      = PW'(wr_a_en) + PW'(wr_b_en);
    wptr_d    = wptr_q + n_wr;
    rptr_d    = rptr_q + PW'(rd_en & ~empty);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we0) mem_q[widx0] <= wdata0;
    if (we1) mem_q[widx1] <= wr_b_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Timestamps retire writes and flushes into a drainable FIFO, counts lost events, flags PC hangs.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HANG_CYCLES = 500,
  parameter int unsigned TS_W        = TraceTsW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  writeback_toARF         commit_i,
  input  logic                   flush_valid_i,
  input  logic [31:0]            flush_address_i,
  input  logic [2:0]             flush_rob_ticket_i,
  input  logic [1:0]             flush_rat_id_i,
  input  logic [31:0]            current_pc_i,
  commit_trace_buffer_if.master  trace,
  output logic [15:0]            drop_count_o,
  output logic                   hang_o
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(HANG_CYCLES + 1);

  logic [TS_W-1:0] ts_q;
  logic [15:0]     drop_q, drop_d;
  logic [16:0]     drop_sum;
  logic [31:0]     old_pc_q, old_pc_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            hang_q, hang_d;

  logic            commit_ev, flush_ev, acc_commit, acc_flush, fifo_empty;
  logic [1:0]      n_drop;
  logic [PW-1:0]   free_cnt;
  trace_entry_t    commit_entry, flush_entry, head;

  trace_fifo_2w1r #(.Depth(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_a_en   (acc_commit),
    .wr_a_data (commit_entry),
    .wr_b_en   (acc_flush),
    .wr_b_data (flush_entry),
    .rd_en     (trace.ready),
    .rd_data   (head),
    .empty     (fifo_empty),
    .free_cnt  (free_cnt)
  );

  assign trace.valid  = ~fifo_empty;
  assign trace.entry  = head;
  assign drop_count_o = drop_q;
  assign hang_o       = hang_q;

  always_comb begin
    commit_ev    = commit_i.valid_commit & ~commit_i.flushed & commit_i.valid_write;
    flush_ev     = flush_valid_i;
    // Free space is judged before this cycle's pop; commit wins the last slot.
    acc_commit   = commit_ev && (free_cnt != '0);
    acc_flush    = flush_ev && (free_cnt >= (commit_ev ? PW'(2) : PW'(1)));
    n_drop       = 2'(commit_ev & ~acc_commit) + 2'(flush_ev & ~acc_flush);
    drop_sum     = 17'(drop_q) + 17'(n_drop);
    drop_d       = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    commit_entry = '{kind: COMMIT, ts: TraceTsW'(ts_q), payload: commit_i.data,
                     tag: commit_i.pdst};
    flush_entry  = '{kind: FLUSH, ts: TraceTsW'(ts_q), payload: flush_address_i,
                     tag: {1'b0, flush_rat_id_i, flush_rob_ticket_i}};

    old_pc_d = old_pc_q;
    stall_d  = stall_q;
    if (current_pc_i == old_pc_q) begin
      if (stall_q != SW'(HANG_CYCLES)) stall_d = stall_q + SW'(1);
    end else begin
      stall_d  = '0;
      old_pc_d = current_pc_i;
    end
    hang_d = hang_q | (stall_d == SW'(HANG_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      drop_q   <= '0;
      old_pc_q <= '0;
      stall_q  <= '0;
      hang_q   <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      drop_q   <= drop_d;
      old_pc_q <= old_pc_d;
      stall_q  <= stall_d;
      hang_q   <= hang_d;
    end
  end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable retire-side trace unit that sits directly downstream of the processor's commit and flush outputs. It timestamps every architectural register write and every pipeline flush, buffers them in a circular FIFO drained over a valid/ready port, and flags a hang once the fetch PC has been frozen for a programmable number of cycles. It is the in-silicon counterpart of the simulation commit/flush logs, so FPGA runs can export the same trace.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥4
- HANG_CYCLES, 500: consecutive unchanged-PC cycles that raise hang
- TS_W, 32: timestamp width
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- commit_i  in  writeback_toARF  retired-instruction bundle (valid_commit, flushed, valid_write, pdst[5:0], data[31:0])
- flush_valid_i  in  1  pipeline flush this cycle
- flush_address_i  in  32  redirect address
- flush_rob_ticket_i  in  3  flushing ROB ticket
- flush_rat_id_i  in  2  RAT checkpoint restored
- current_pc_i  in  32  fetch PC
- out_valid_o  out  1  head entry available
- out_ready_i  in  1  consumer accepts head
- out_entry_o  out  trace_entry_t  {kind, ts[TS_W-1:0], payload[31:0], tag[5:0]}
- drop_count_o  out  16  saturating count of lost events
- hang_o  out  1  sticky PC-hang flag

## Operation
- Commit event: commit_i.valid_commit & !flushed & valid_write; entry kind=COMMIT, payload=data, tag=pdst.
- Flush event: flush_valid_i; kind=FLUSH, payload=flush_address_i, tag={1'b0, rat_id[1:0], rob_ticket[2:0]}.
- ts = free-running cycle counter, 0 on reset, +1 every cycle, wraps modulo 2^TS_W; both events in one cycle carry the same ts.
- FIFO has two write ports; same-cycle events written commit first, flush second.
- Free slots are evaluated before the same-cycle pop: 0 free → both events dropped; 1 free → commit written, flush dropped; ≥2 free → both written.
- drop_count_o += number of dropped events (0, 1 or 2), saturating at 16'hFFFF.
- Read: first-word fall-through; pop when out_valid_o & out_ready_i; out_entry_o held stable while valid & !ready.
- Pointers are log2(DEPTH)+1 bits; full/empty from the MSB-compare rule; wrap is natural.
- Hang: old_pc register and a stall counter. If current_pc_i == old_pc, counter increments, saturating at HANG_CYCLES. Otherwise the counter clears and old_pc loads current_pc_i. hang_o sets when the counter reaches HANG_CYCLES and stays set until reset.

## Timing
- Reset values: out_valid_o=0, out_entry_o=0, drop_count_o=0, hang_o=0, ts=0, old_pc=0, stall counter=0, pointers=0.
- Event in cycle N → out_valid_o high in cycle N+1 (empty FIFO), with ts = value sampled in cycle N.
- Pop and write in the same cycle on a non-full FIFO: both take effect; occupancy changes by writes−1.
- hang_o rises on the clock edge where the counter transitions HANG_CYCLES−1 → HANG_CYCLES.
- Reset asserted mid-operation clears all state immediately; buffered entries are lost and not counted as drops.

## Structure
- Shared package: trace_kind_e {COMMIT=1'b0, FLUSH=1'b1} and trace_entry_t. writeback_toARF comes from the existing structs package.
- Sub-module trace_fifo_2w1r: parameterized two-write, one-read circular buffer reporting free-slot count. Capture, drop accounting and hang logic stay in the top module.

## Test plan
- Single commit (pdst=9, data=32'hDEADBEEF) at ts=10 → one entry {COMMIT, ts=10, 32'hDEADBEEF, 9} valid next cycle; a commit with flushed=1 or valid_write=0 produces nothing.
- Same-cycle commit and flush (adr=32'h100, rob=5, rat=2) → two entries, commit then flush, equal ts, flush tag=6'b010101.
- Hold out_ready_i=0 and issue 18 commits with DEPTH=16 → 16 entries retained in order, drop_count_o=2. Then drain with ready=1 → FIFO empty, out_valid_o=0.
- 15 entries buffered, then commit+flush in one cycle → commit kept, flush dropped, drop_count_o+=1.
- PC held constant → hang_o=0 after 499 cycles, 1 after 500. A PC change afterward leaves hang_o=1. Reset clears it.
- Assert rst_n low with 5 entries buffered → out_valid_o=0 and drop_count_o=0 asynchronously. After release, ts restarts at 0.
